// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - complementary half-bridge gate drive with break-before-make dead time
// Optional latched fault input and FAULT state when PWM_DT_FAULT_EN is defined.
module pwm_deadtime_gen #(
  parameter int DT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_a,
  input  logic                en,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                pwm_in,
`ifdef PWM_DT_FAULT_EN
  input  logic                fault,
  input  logic                fault_clr,
  output logic                fault_latched,
`endif
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                busy
);

`ifdef PWM_DT_FAULT_EN
  typedef enum logic [2:0] {IDLE, H_ON, L_ON, DEAD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, H_ON, L_ON, DEAD} state_t;
`endif

  state_t              state, state_next;
  logic [DT_WIDTH-1:0] cnt, cnt_next;
  logic [DT_WIDTH-1:0] dt_n;
  logic                pwm_s;

  assign dt_n = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        state_next = DEAD;
        cnt_next   = dt_n;
      end
      H_ON: if (!pwm_s) begin
        state_next = DEAD;
        cnt_next   = dt_n;
      end
      L_ON: if (pwm_s) begin
        state_next = DEAD;
        cnt_next   = dt_n;
      end
      DEAD: begin
        // The counter holds the remaining low cycles, so the exit edge is the one that consumes the last.
        if (cnt <= DT_WIDTH'(1)) begin
          state_next = pwm_s ? H_ON : L_ON;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - DT_WIDTH'(1);
        end
      end
`ifdef PWM_DT_FAULT_EN
      FAULT: if (fault_clr && !fault) begin
        state_next = DEAD;
        cnt_next   = dt_n;
      end
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

`ifdef PWM_DT_FAULT_EN
    if (fault) begin
      state_next = FAULT;
      cnt_next   = '0;
    end else if (!en && state_next != FAULT) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
`else
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
`endif
  end

  // Gates are registered from the next state so they never glitch on decode.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      state         <= IDLE;
      cnt           <= '0;
      pwm_s         <= 1'b0;
      pwm_h         <= 1'b0;
      pwm_l         <= 1'b0;
      busy          <= 1'b0;
`ifdef PWM_DT_FAULT_EN
      fault_latched <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      pwm_s         <= pwm_in;
      pwm_h         <= (state_next == H_ON);
      pwm_l         <= (state_next == L_ON);
      busy          <= (state_next == DEAD);
`ifdef PWM_DT_FAULT_EN
      fault_latched <= (state_next == FAULT);
`endif
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb/tb_pwm_deadtime_gen.sv - self-checking bench for pwm_deadtime_gen
// Exercises the fault path as well when PWM_DT_FAULT_EN is defined.
module tb_pwm_deadtime_gen;
  localparam int DT_WIDTH = 4;

  logic                clk = 1'b0;
  logic                rst_a = 1'b0;
  logic                en = 1'b0;
  logic                pwm_in = 1'b0;
  logic                fault = 1'b0;
  logic                fault_clr = 1'b0;
  logic [DT_WIDTH-1:0] dead_time = '0;
  logic                pwm_h, pwm_l, busy;
`ifdef PWM_DT_FAULT_EN
  logic                fault_latched;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: which gate is on (0 none, 1 high, 2 low) and how many dead cycles remain.
  logic m_pwm_s = 1'b0;
  int   m_side = 0;
  int   m_dead = 0;
  logic m_fault = 1'b0;

  typedef struct {
    logic                rst;
    logic                en;
    logic [DT_WIDTH-1:0] dt;
    logic                pwm;
    logic [2:0]          exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pwm_deadtime_gen #(.DT_WIDTH(DT_WIDTH)) dut (
    .clk          (clk),
    .rst_a        (rst_a),
    .en           (en),
    .dead_time    (dead_time),
    .pwm_in       (pwm_in),
`ifdef PWM_DT_FAULT_EN
    .fault        (fault),
    .fault_clr    (fault_clr),
    .fault_latched(fault_latched),
`endif
    .pwm_h        (pwm_h),
    .pwm_l        (pwm_l),
    .busy         (busy)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_edge();
    int   n;
    logic s;
    n = (dead_time == 0) ? 1 : int'(dead_time);
    s = m_pwm_s;
    if (!rst_a) begin
      m_side = 0; m_dead = 0; m_fault = 1'b0; m_pwm_s = 1'b0;
      return;
    end
    if (fault) begin
      m_fault = 1'b1; m_side = 0; m_dead = 0;
    end else if (m_fault) begin
      if (fault_clr) begin
        m_fault = 1'b0; m_side = 0; m_dead = en ? n : 0;
      end
    end else if (!en) begin
      m_side = 0; m_dead = 0;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) m_side = s ? 1 : 2;
    end else if (m_side == 0 || (m_side == 1 && !s) || (m_side == 2 && s)) begin
      m_side = 0; m_dead = n;
    end
    m_pwm_s = pwm_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_gates", {29'd0, pwm_h, pwm_l, busy},
          {29'd0, m_side == 1, m_side == 2, m_dead > 0});
    check("overlap", {31'd0, pwm_h & pwm_l}, 32'd0);
`ifdef PWM_DT_FAULT_EN
    check("model_fault_latched", {31'd0, fault_latched}, {31'd0, m_fault});
`endif
  endtask

  task automatic add(logic r, logic e, int dt, logic p, logic [2:0] x);
    vec_t v;
    v.rst = r; v.en = e; v.dt = DT_WIDTH'(dt); v.pwm = p; v.exp = x;
    vecs.push_back(v);
  endtask

  initial begin
    int n_low, h_cnt, l_cnt;
    logic h_seen;

    // exp = {pwm_h, pwm_l, busy}
    add(0, 0, 3, 0, 3'b000);
    add(1, 1, 3, 0, 3'b001); add(1, 1, 3, 0, 3'b001); add(1, 1, 3, 0, 3'b001);
    add(1, 1, 3, 0, 3'b010); add(1, 1, 3, 0, 3'b010);
    add(1, 1, 3, 1, 3'b010);
    add(1, 1, 3, 1, 3'b001); add(1, 1, 3, 1, 3'b001); add(1, 1, 3, 1, 3'b001);
    add(1, 1, 3, 1, 3'b100); add(1, 1, 3, 1, 3'b100);
    add(1, 0, 3, 1, 3'b000);
    add(1, 1, 3, 1, 3'b001); add(1, 1, 3, 1, 3'b001);
    add(0, 1, 3, 1, 3'b000);
    add(1, 1, 3, 1, 3'b001); add(1, 1, 3, 1, 3'b001); add(1, 1, 3, 1, 3'b001);
    add(1, 1, 3, 1, 3'b100);
    add(1, 1, 0, 0, 3'b100); add(1, 1, 0, 0, 3'b001); add(1, 1, 0, 0, 3'b010);
    add(1, 1, 2, 1, 3'b010); add(1, 1, 2, 1, 3'b001);
    add(1, 1, 7, 1, 3'b001); add(1, 1, 7, 1, 3'b100);
    add(1, 1, 15, 0, 3'b100); add(1, 1, 15, 0, 3'b001);
    for (int i = 0; i < 14; i++) add(1, 1, 15, 0, 3'b001);
    add(1, 1, 15, 0, 3'b010);

    foreach (vecs[i]) begin
      rst_a = vecs[i].rst; en = vecs[i].en; dead_time = vecs[i].dt; pwm_in = vecs[i].pwm;
      step();
      check($sformatf("vec%0d", i), {29'd0, pwm_h, pwm_l, busy}, {29'd0, vecs[i].exp});
    end

    // Square wave, period 8, dead_time 0 -> one dead cycle per edge.
    dead_time = '0;
    h_cnt = 0; l_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      pwm_in = ((i % 8) < 4);
      step();
      if (i >= 24 && i < 32) begin
        h_cnt += int'(pwm_h);
        l_cnt += int'(pwm_l);
      end
    end
    check("square_h_cycles", h_cnt, 3);
    check("square_l_cycles", l_cnt, 3);

    // One-cycle high glitch while low side is on must not flip sides or shorten the interval.
    dead_time = 4'd5; pwm_in = 1'b0;
    for (int i = 0; i < 40 && !(pwm_l && !busy); i++) step();
    check("pulse_settle_l", {31'd0, pwm_l}, 32'd1);
    pwm_in = 1'b1; step();
    pwm_in = 1'b0; step();
    n_low = 0; h_seen = 1'b0;
    for (int i = 0; i < 20 && !pwm_l; i++) begin
      if (!pwm_h && !pwm_l) n_low++;
      if (pwm_h) h_seen = 1'b1;
      step();
    end
    check("pulse_dead_cycles", n_low, 5);
    check("pulse_l_back", {31'd0, pwm_l}, 32'd1);
    check("pulse_h_never", {31'd0, h_seen}, 32'd0);

`ifdef PWM_DT_FAULT_EN
    dead_time = 4'd2; pwm_in = 1'b1;
    for (int i = 0; i < 40 && !pwm_h; i++) step();
    check("fault_pre_h", {31'd0, pwm_h}, 32'd1);
    fault = 1'b1; step();
    check("fault_h_off", {30'd0, pwm_h, fault_latched}, 32'd1);
    fault_clr = 1'b1; step();
    check("fault_clr_ignored", {31'd0, fault_latched}, 32'd1);
    fault = 1'b0; fault_clr = 1'b0; step();
    check("fault_held", {31'd0, fault_latched}, 32'd1);
    fault_clr = 1'b1; step();
    check("fault_exit", {30'd0, fault_latched, busy}, 32'd1);
    fault_clr = 1'b0;
    n_low = 0;
    for (int i = 0; i < 20 && !pwm_h; i++) begin
      n_low++;
      step();
    end
    check("fault_dead_cycles", n_low, 2);
`endif

    // Randomised run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst_a = ($urandom_range(199) != 0);
      en = ($urandom_range(39) != 0);
      if ($urandom_range(29) == 0) dead_time = DT_WIDTH'($urandom_range(15));
      if ($urandom_range(5) == 0) pwm_in = ~pwm_in;
`ifdef PWM_DT_FAULT_EN
      fault = ($urandom_range(99) == 0);
      fault_clr = ($urandom_range(7) == 0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
Downstream stage of the PWM top level. It consumes the single-ended pwm output and drives a complementary high-side/low-side gate pair for a half-bridge. It inserts a programmable break-before-make dead interval on every transition. Both gates are never high in the same cycle.

Parameters:
DT_WIDTH, 4, width of the dead_time input and the internal dead counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_a  input  1  synchronous, active-low reset; sampled on the clk rising edge
en  input  1  output enable; 0 forces both gates low
dead_time  input  DT_WIDTH  dead interval in clk cycles; 0 is treated as 1
pwm_in  input  1  PWM from the PWM top level, synchronous to clk
pwm_h  output  1  high-side gate drive
pwm_l  output  1  low-side gate drive
busy  output  1  1 while a dead interval is in progress

Behaviour:
- Reset (rst_a=0 at an edge): pwm_h=0, pwm_l=0, busy=0, state=IDLE, pwm_s=0, dead counter=0.
- pwm_s is pwm_in registered once. All decisions use pwm_s, never pwm_in directly.
- N = max(dead_time,1). dead_time is latched when a dead interval is entered. Changes during the interval are ignored.
- States: IDLE, H_ON, L_ON, DEAD.
- IDLE: both gates low. On en=1, go to DEAD and load N.
- H_ON: pwm_h=1, pwm_l=0. If pwm_s=0 or en=0: next edge pwm_h=0, go to DEAD (or to IDLE if en=0).
- L_ON: pwm_l=1, pwm_h=0. Mirror of H_ON, triggered by pwm_s=1.
- DEAD: both gates low, busy=1, counter decrements each edge. When counter reaches 0, the next edge selects the side from pwm_s at that edge: 1 selects H_ON, 0 selects L_ON. busy falls on that same edge.
- Exactly N consecutive cycles with both gates low per dead interval.
- Latency: pwm_in change → old gate falls on 2nd rising edge. New gate rises N edges after that.
- Short pulse: if pwm_s reverts during DEAD, the final pwm_s level decides the side. The previous side may re-enable after the full N dead cycles. The interval is never shortened.
- en=0 in any state: both gates low at the next edge, state=IDLE, counter cleared. This has priority over all transitions.
- Reset mid-interval: returns to the reset values at that edge. There is no partial drive.
- Invariant: pwm_h & pwm_l == 0 in every cycle, including the cycle after reset and after en toggles.
- dead_time all-ones gives a 2^DT_WIDTH-1 cycle interval. The counter does not wrap.

Optional Feature:
Macro PWM_DT_FAULT_EN.
- Defined:
  - Adds ports fault (input 1, active-high, synchronous), fault_clr (input 1) and fault_latched (output 1, reset 0).
  - fault=1 at an edge sets both gates low and fault_latched=1 at that edge. State becomes FAULT. fault has priority over en and all other transitions.
  - FAULT exits only on an edge with fault_clr=1 and fault=0. fault_latched clears on that edge.
  - The exit goes to DEAD with N loaded, or to IDLE if en=0.
- Undefined: the ports and the FAULT state do not exist. Behaviour is exactly as above.

Test Plan:
- Reset, en=1, dead_time=3, pwm_in=0 constant → 3 cycles both low (busy=1), then pwm_l=1, pwm_h=0 held.
- In L_ON, dead_time=3, pwm_in 0→1 sampled at edge k → pwm_l=0 at edge k+1, pwm_h=1 at edge k+4, busy=1 over edges k+1..k+3.
- dead_time=0, 50% square wave of period 8 → 1 dead cycle per transition, each gate high 3 cycles. Checker confirms pwm_h&pwm_l never 1.
- dead_time=5, one-cycle pwm_in high pulse while in L_ON → both low for exactly 5 cycles, then pwm_l=1 again. pwm_h never asserts.
- en dropped mid-H_ON, then rst_a=0 mid-DEAD → both low next edge, IDLE. After reset, all outputs 0 and the counter restarts at the full N.
- (PWM_DT_FAULT_EN) fault pulse in H_ON → pwm_h=0 and fault_latched=1 next edge. A fault_clr asserted while fault=1 is ignored. After fault=0 and fault_clr=1 → N dead cycles, then the gate follows pwm_in.
